// File: rtl/act_pwq_eval.sv
// -----------------------------------------------------------------------------
// act_pwq_eval
//
// Piecewise-quadratic activation evaluator. Each accepted x_in is evaluated as
//   y = c0 + u*(c1 + c2*u),  u = |x_in|  (|most-negative| saturates to max)
// The evaluation uses a single shared signed DWIDTH x DWIDTH multiplier, which
// is used twice per operation:
//   t = c1 + ((c2*u) >>> FRAC)
//   y = c0 + ((t*u)  >>> FRAC)
// Each product is arithmetic-shifted right by FRAC, so it rounds toward minus
// infinity, and then truncated to DWIDTH bits. The additions wrap.
//
// Segment selection from k = u >> FRAC:
//   k = 0..3 -> seg k,  k = 4..5 -> seg 4,  k >= 6 -> seg 6 (constant ONE)
//
// Optional feature (compile-time macro ACT_SYMMETRY_EN):
//   When defined, a negative x_in yields ONE - f(u). The subtraction is folded
//   into the final register update, so the latency does not change. When the
//   macro is undefined, the design has no sign register and no subtractor.
//
// Parameters:
//   DWIDTH  signed data width of x, coefficients and y (default 32)
//   FRAC    fractional bits of every fixed-point value (default 24)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   x_in valid
//   in_ready   block can accept x_in (asserted only in IDLE)
//   x_in       signed input sample
//   out_valid  y_out/seg_out valid (asserted only in DONE)
//   out_ready  consumer accepts the result
//   y_out      registered result
//   seg_out    registered segment index of the result
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for in_valid; captures |x_in| on accept
//   SEG   | segment index decoded from u
//   MUL1  | t = c1 + ((c2*u) >>> FRAC)
//   MUL2  | y = c0 + ((t*u) >>> FRAC), registered to y_out/seg_out
//   DONE  | result presented until out_ready
// -----------------------------------------------------------------------------
module act_pwq_eval #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] y_out,
  output logic [2:0]        seg_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEG  = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic signed [DWIDTH-1:0] MAX_POS = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  // The coefficient table is written in Q8.24; rescale it to FRAC.
  localparam int SH_L = (FRAC >= 24) ? (FRAC - 24) : 0;
  localparam int SH_R = (FRAC <  24) ? (24 - FRAC) : 0;

`ifdef ACT_SYMMETRY_EN
  localparam logic signed [DWIDTH-1:0] ONE = DWIDTH'(1) << FRAC;
`endif

  function automatic logic signed [DWIDTH-1:0] coef(input logic [31:0] h);
    logic signed [63:0] w;
    w = {{32{h[31]}}, h};
    w = (w <<< SH_L) >>> SH_R;
    return w[DWIDTH-1:0];
  endfunction

  state_t state, state_nx;

  logic signed [DWIDTH-1:0]   u_reg;
  logic signed [DWIDTH-1:0]   t_reg;
  logic [2:0]                 seg_reg;
`ifdef ACT_SYMMETRY_EN
  logic                       neg_reg;
`endif

  logic signed [DWIDTH-1:0]   u_abs;
  logic [DWIDTH-1:0]          k;
  logic [2:0]                 seg_sel;
  logic signed [DWIDTH-1:0]   c0, c1, c2;
  logic signed [DWIDTH-1:0]   mul_a;
  logic signed [2*DWIDTH-1:0] a_ext, b_ext, prod, prod_sh;
  logic signed [DWIDTH-1:0]   mul_q;
  logic signed [DWIDTH-1:0]   y_f;
  logic [DWIDTH-1:0]          y_next;
  logic                       accept;

  // Magnitude with saturation. Negating the most-negative value would wrap
  // back to itself, so that case maps to the largest positive value.
  always_comb begin
    u_abs = x_in;
    if (x_in == MIN_NEG)
      u_abs = MAX_POS;
    else if (x_in[DWIDTH-1])
      u_abs = -$signed(x_in);
  end

  // u_reg is never negative, so a logical shift gives the integer part.
  always_comb begin
    k       = $unsigned(u_reg) >> FRAC;
    seg_sel = 3'd6;
    if (k < DWIDTH'(4))
      seg_sel = k[2:0];
    else if (k < DWIDTH'(6))
      seg_sel = 3'd4;
  end

  always_comb begin
    c0 = coef(32'h0100_0000);
    c1 = coef(32'h0000_0000);
    c2 = coef(32'h0000_0000);
    case (seg_reg)
      3'd0: begin
        c0 = coef(32'h0080_0000);
        c1 = coef(32'h0040_0000);
        c2 = coef(32'h0000_0000);
      end
      3'd1: begin
        c0 = coef(32'h00D1_4000);
        c1 = coef(32'h0026_0000);
        c2 = coef(32'hFFF4_0000);
      end
      3'd2: begin
        c0 = coef(32'h00EC_8000);
        c1 = coef(32'h0011_C000);
        c2 = coef(32'hFFF8_8000);
      end
      3'd3: begin
        c0 = coef(32'h00F8_4000);
        c1 = coef(32'h0007_4000);
        c2 = coef(32'hFFFC_C000);
      end
      3'd4: begin
        c0 = coef(32'h00FE_4000);
        c1 = coef(32'h0001_8000);
        c2 = coef(32'hFFFF_4000);
      end
      default: begin
        c0 = coef(32'h0100_0000);
        c1 = coef(32'h0000_0000);
        c2 = coef(32'h0000_0000);
      end
    endcase
  end

  // Shared multiplier: c2*u in MUL1, t*u in MUL2. The operands are
  // sign-extended to full width, so the low 2*DWIDTH bits of the product
  // are the exact signed product.
  always_comb begin
    mul_a   = (state == MUL2) ? t_reg : c2;
    a_ext   = {{DWIDTH{mul_a[DWIDTH-1]}}, mul_a};
    b_ext   = {{DWIDTH{u_reg[DWIDTH-1]}}, u_reg};
    prod    = a_ext * b_ext;
    prod_sh = prod >>> FRAC;
    mul_q   = prod_sh[DWIDTH-1:0];
  end

  always_comb begin
    y_f = c0 + mul_q;
`ifdef ACT_SYMMETRY_EN
    y_next = neg_reg ? (ONE - y_f) : y_f;
`else
    y_next = y_f;
`endif
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = SEG;
      end
      SEG:  state_nx = MUL1;
      MUL1: state_nx = MUL2;
      MUL2: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_reg   <= '0;
      t_reg   <= '0;
      seg_reg <= '0;
      y_out   <= '0;
      seg_out <= '0;
`ifdef ACT_SYMMETRY_EN
      neg_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            u_reg <= u_abs;
`ifdef ACT_SYMMETRY_EN
            neg_reg <= x_in[DWIDTH-1];
`endif
          end
        end
        SEG:  seg_reg <= seg_sel;
        MUL1: t_reg   <= c1 + mul_q;
        MUL2: begin
          y_out   <= y_next;
          seg_out <= seg_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_act_pwq_eval.sv
// Scoreboard bench for act_pwq_eval. The driver pushes the expected result
// when an input is accepted. A negedge monitor pops an entry and compares it
// on every output handshake, and also checks the accept-to-valid latency.
module tb_act_pwq_eval;

`ifdef ACT_SYMMETRY_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y_out;
  logic [2:0]  seg_out;

  act_pwq_eval #(.DWIDTH(32), .FRAC(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .seg_out   (seg_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] y;
    logic [2:0]  seg;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] exp_y(input logic [31:0] x, input logic [31:0] f);
    return (SYM && x[31]) ? (32'h0100_0000 - f) : f;
  endfunction

  // Monitor
  bit lat_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_done = 1'b0;
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!lat_done) begin
            chk("latency", 32'(cyc - sbq[0].acc), 32'd4);
            lat_done = 1'b1;
          end
          if (out_ready) begin
            e = sbq.pop_front();
            chk("y_out", y_out, e.y);
            chk("seg_out", {29'd0, seg_out}, {29'd0, e.seg});
            lat_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] f, input logic [2:0] s,
                      input bit push, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    x_in = x;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      acc = cyc;
      if (push) sbq.push_back('{exp_y(x, f), s, cyc});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_queue_size", 32'(sbq.size()), 32'd0);
  endtask

  // x, f(|x|) before symmetry, segment
  localparam int NV = 14;
  logic [31:0] vx [NV] = '{32'h0000_0000, 32'h0080_0000, 32'h0000_0001, 32'h0100_0000,
                           32'h0100_0001, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000,
                           32'h0500_0000, 32'h0600_0000, 32'h0800_0000, 32'h8000_0000,
                           32'hFF80_0000, 32'hFF00_0000};
  logic [31:0] vf [NV] = '{32'h0080_0000, 32'h00A0_0000, 32'h0080_0000, 32'h00EB_4000,
                           32'h00EB_3FFF, 32'h00F2_0000, 32'h00F0_C000, 32'h00F8_4000,
                           32'h00F3_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000,
                           32'h00A0_0000, 32'h00EB_4000};
  logic [2:0]  vs [NV] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                           3'd4, 3'd6, 3'd6, 3'd6, 3'd0, 3'd1};

  initial begin
    int acc, prev;
    bit seen;

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y_out", y_out, 32'd0);
    chk("rst_seg_out", {29'd0, seg_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back vectors, out_ready high: one result every 5 cycles
    prev = 0;
    for (int i = 0; i < NV; i++) begin
      send(vx[i], vf[i], vs[i], 1'b1, acc);
      if (i > 0) chk("throughput", 32'(acc - prev), 32'd5);
      prev = acc;
    end
    drain();

    // hold the result with out_ready low; a pulsed in_valid must be ignored
    out_ready = 1'b0;
    send(32'h0100_0000, 32'h00EB_4000, 3'd1, 1'b1, acc);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("hold_reach_done", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_y_out", y_out, 32'h00EB_4000);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      if (i == 3) begin
        x_in = 32'h0000_0000;
        in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("ignored_pulse_no_output", {31'd0, seen}, 32'd0);

    // reset pulse during MUL1 discards the in-flight operation
    send(32'h0200_0000, 32'h00F2_0000, 3'd2, 1'b0, acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_y_out", y_out, 32'd0);
    chk("abort_seg_out", {29'd0, seg_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready_first", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'd0, seen}, 32'd0);

    // normal operation after the abort
    send(32'h0080_0000, 32'h00A0_0000, 3'd0, 1'b1, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
